// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and widths for the sequential 8x8 multiplier.
package mul_seq_pkg;
  localparam int MUL_W = 8;
  localparam int PROD_W = 2 * MUL_W;
  localparam int ITER_W = $clog2(MUL_W);
  typedef enum logic [2:0] {S_A, S_B, S_RUN, S_HI, S_LO} state_t;
endpackage

// File: rtl/mul_shift_add_core.sv
// mul_shift_add_core: one conditional shift-add per step, bit index advances internally.
module mul_shift_add_core
  import mul_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] product
);
  logic [ITER_W-1:0] idx;
  always_ff @(posedge clk) begin
    if (rst || load) begin
      product <= '0;
      idx     <= '0;
    end else if (step) begin
      product <= b[idx] ? product + (PROD_W'(a) << idx) : product;
      idx     <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: byte-stream operand loader, fixed-latency sequencer and two-byte result unloader.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [OPS_W-1:0] op_count
);
  if (WIDTH != MUL_W) begin : g_width_check
    $error("mul_seq_ctrl: only WIDTH=8 is supported");
  end
  state_t            state;
  logic [MUL_W-1:0]  a_q, b_q;
  logic [ITER_W-1:0] iter;
  logic [PROD_W-1:0] product;
  logic              load, step;
  assign load = (state == S_B) && in_valid;
  assign step = (state == S_RUN);
  // Product settles on the same edge that enters S_HI, so the byte mux reads it directly.
  assign out_data = !out_valid ? '0 : (state == S_HI) ? product[PROD_W-1:MUL_W] : product[MUL_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      iter      <= '0;
      op_count  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_A: if (in_valid) begin
          a_q   <= in_data;
          busy  <= 1'b1;
          state <= S_B;
        end
        S_B: if (in_valid) begin
          b_q      <= in_data;
          iter     <= '0;
          in_ready <= 1'b0;
          state    <= S_RUN;
        end
        S_RUN: begin
          iter <= iter + 1'b1;
          if (iter == ITER_W'(MUL_W - 1)) begin
            out_valid <= 1'b1;
            state     <= S_HI;
          end
        end
        S_HI: if (out_ready) state <= S_LO;
        S_LO: if (out_ready) begin
          op_count  <= op_count + 1'b1;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end
  mul_shift_add_core u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .a       (a_q),
    .b       (b_q),
    .product (product)
  );
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and random operations checked against a*b and fixed-latency expectations.
module tb_mul_seq_ctrl;
  logic       clk = 0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic [7:0] op_count;
  int tests = 0;
  int fails = 0;
  int exp_ops = 0;
  mul_seq_ctrl #(.WIDTH(8), .OPS_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hi_stall, input int lo_stall, input bit junk);
    logic [15:0] p;
    logic [7:0]  hold;
    int          lat;
    bit          ok;
    p = 16'(a) * 16'(b);
    chk("idle_ready", {busy, in_ready, out_valid}, 3'b010);
    in_valid = 1; in_data = a;
    tick();
    chk("b_phase", {busy, in_ready, out_valid}, 3'b110);
    in_data = b;
    tick();
    in_valid = junk; in_data = 8'h55;
    lat = 1; ok = 1;
    while (!out_valid && lat < 20) begin
      if (in_ready || !busy) ok = 0;
      tick();
      lat++;
    end
    chk("latency", lat, 9);
    chk("run_blocked", ok, 1);
    chk("hi_byte", {out_valid, in_ready, out_data}, {2'b10, p[15:8]});
    hold = out_data; ok = 1;
    repeat (hi_stall) begin
      tick();
      if (!out_valid || in_ready || out_data !== hold) ok = 0;
    end
    chk("hi_stable", ok, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("lo_byte", {out_valid, in_ready, out_data}, {2'b10, p[7:0]});
    hold = out_data; ok = 1;
    repeat (lo_stall) begin
      tick();
      if (!out_valid || in_ready || out_data !== hold) ok = 0;
    end
    chk("lo_stable", ok, 1);
    out_ready = 1;
    tick();
    out_ready = 0; in_valid = 0;
    exp_ops = (exp_ops + 1) % 256;
    chk("done_flags", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
    chk("op_count", op_count, exp_ops);
  endtask
  initial begin
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0;
    repeat (3) tick();
    rst = 0;
    chk("reset_flags", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
    chk("reset_ops", op_count, 0);
    run_op(8'd13, 8'd11, 0, 0, 0);
    run_op(8'hFF, 8'hFF, 5, 3, 1);
    run_op(8'h00, 8'hFF, 0, 0, 0);
    run_op(8'hFF, 8'h00, 1, 1, 1);
    in_valid = 1; in_data = 8'h77;
    tick();
    in_data = 8'h99;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    exp_ops = 0;
    chk("midrst_flags", {in_ready, out_valid, busy, out_data}, {3'b100, 8'h00});
    chk("midrst_ops", op_count, 0);
    run_op(8'd3, 8'd4, 0, 0, 0);
    repeat (20) run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    rst = 1;
    tick();
    rst = 0;
    exp_ops = 0;
    repeat (256) run_op(8'd1, 8'd1, 0, 0, 0);
    chk("wrap_zero", op_count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Operand loader and sequencer for an iterative 8x8 unsigned shift-add multiplier.
- Sits between the top-level byte-wide pins (ui_in/uo_out, wired by the top wrapper) and the multiplier datapath.
- Accepts operand A, then operand B, over an 8-bit valid/ready input stream, runs the core for a fixed number of cycles, then returns the 16-bit product as two bytes, high byte first, over a valid/ready output stream.

Parameters:
- WIDTH, 8, operand width and byte-bus width; only 8 is supported. The implementation must stop elaboration on any other value.
- OPS_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset. The top wrapper drives it as ~rst_n.
- in_valid  in  1  in_data holds an operand byte.
- in_data  in  WIDTH  operand byte.
- in_ready  out  1  controller accepts a byte this cycle.
- out_valid  out  1  out_data holds a result byte.
- out_data  out  WIDTH  result byte.
- out_ready  in  1  consumer takes the byte this cycle.
- busy  out  1  high in any state other than S_A.
- op_count  out  OPS_W  number of completed operations; wraps.

Behaviour:
- Reset: synchronous, active-high, takes priority over everything, including mid-operation.
  - State goes to S_A; in_ready=1, out_valid=0, out_data=0, busy=0, op_count=0.
  - Operand registers, product and iteration counter are cleared.
- Transfer rule: a transfer occurs only on a cycle where valid&&ready. Inputs are sampled at the rising edge.
- States: S_A, S_B, S_RUN, S_HI, S_LO.
- S_A:
  - in_ready=1.
  - On transfer: latch A, go to S_B.
- S_B:
  - in_ready=1.
  - On transfer: latch B, clear product, set iteration counter to 0, go to S_RUN.
- S_RUN:
  - in_ready=0; in_valid is ignored and no data is latched.
  - Each cycle: if B[i]==1, product += A<<i, then i++.
  - Exactly WIDTH cycles; go to S_HI after i==WIDTH-1.
  - The addition is 2*WIDTH bits wide and never overflows.
- S_HI:
  - out_valid=1, out_data=product[15:8].
  - Hold until out_ready, then go to S_LO.
- S_LO:
  - out_valid=1, out_data=product[7:0].
  - On out_ready: op_count++ (wraps 2^OPS_W-1 -> 0), go to S_A.
- out_data is 0 whenever out_valid=0. Output data must stay stable while out_valid=1 and out_ready=0.
- Latency: if B is accepted at edge k, the core is in S_RUN for cycles k+1..k+WIDTH and out_valid first rises in cycle k+WIDTH+1. With out_ready held high, S_LO is cycle k+WIDTH+2 and in_ready rises in cycle k+WIDTH+3.
- No overlap: the next operand A cannot be accepted until S_LO completes.
- Zero operands are not short-cut; latency is always fixed.
- out_ready outside S_HI/S_LO is ignored.
- Simultaneous in_valid and out_ready cannot both take effect, because the in_ready and out_valid phases are disjoint.

Decomposition:
- Package mul_seq_pkg holds:
  - the state enum: S_A, S_B, S_RUN, S_HI, S_LO;
  - localparams PROD_W = 2*WIDTH and ITER_W = $clog2(WIDTH).
- Sub-module mul_shift_add_core is the datapath.
  - Ports: clk, rst, load, step, a, b, product.
  - load clears the product; step performs one conditional add and advances its internal bit index.
- mul_seq_ctrl contains the FSM, the handshakes, the iteration counter and the op counter, and drives load/step.

Test Plan:
- Basic product: A=13, B=11, out_ready=1.
  - B accepted at edge k; out_valid rises in cycle k+9.
  - Output bytes are 0x00 then 0x8F (143); op_count=1.
- Maximum operands: A=0xFF, B=0xFF -> bytes 0xFE then 0x01. A=0, B=0xFF -> bytes 0x00, 0x00, still at the full 8-cycle latency.
- Output backpressure:
  - out_ready=0 for 5 cycles in S_HI -> out_valid stays 1 and out_data stays 0xFE.
  - Asserting out_ready then advances to S_LO; hold it low 3 more cycles -> 0x01 stays stable.
- Input during compute: in_valid=1 with in_data=0x55 throughout S_RUN/S_HI/S_LO -> in_ready=0, and the result is unaffected.
  - The next accepted byte becomes A only after S_LO completes.
- Reset mid-operation: assert rst in the 4th S_RUN cycle.
  - Next cycle: S_A, out_valid=0, busy=0, op_count=0.
  - A following 3x4 operation returns 0x00 then 0x0C.
- Counter wrap: 256 back-to-back operations of 1x1 -> op_count returns to 0. Every result is 0x00 then 0x01.
